// File: rtl/vscale_dmem_ahb_bridge.sv
// vscale data-memory port to AHB-Lite master bridge.
// Tracks the single outstanding data phase, flags misaligned requests
// locally, maps HRESP errors to dmem_badmem_e and can abandon a hung slave.
//
// Handshake: the pipeline presents a request (dmem_en) as an AHB address
// phase in the same cycle. The request is accepted when the bridge drives
// NONSEQ while hready is high. The following cycle is the data phase, which
// completes on the first cycle where dmem_wait is low. While dmem_wait is
// high, the pipeline holds its address-phase inputs stable.
module vscale_dmem_ahb_bridge #(
  parameter int ADDR_W         = 32,
  parameter int MEM_TYPE_WIDTH = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dmem_en,
  input  logic                      dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] dmem_size,
  input  logic [ADDR_W-1:0]         dmem_addr,
  input  logic [ADDR_W-1:0]         dmem_wdata_delayed,
  output logic                      dmem_wait,
  output logic [ADDR_W-1:0]         dmem_rdata,
  output logic                      dmem_badmem_e,
  output logic [ADDR_W-1:0]         haddr,
  output logic                      hwrite,
  output logic [2:0]                hsize,
  output logic [1:0]                htrans,
  output logic [ADDR_W-1:0]         hwdata,
  input  logic [ADDR_W-1:0]         hrdata,
  input  logic                      hready,
  input  logic                      hresp,
  output logic                      timeout_flag,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS   = 2'd1,
    S_MISAL = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // A zero TIMEOUT_CYCLES disables the timeout entirely.
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             wr_q;
  logic             misal;
  logic             tmo_fire;
  logic             advance;
  logic             accept;

  // Alignment check; sizes above word are not supported and count as misaligned.
  always_comb begin
    misal = 1'b1;
    if (dmem_size == MEM_TYPE_WIDTH'(0)) begin
      misal = 1'b0;
    end else if (dmem_size == MEM_TYPE_WIDTH'(1)) begin
      misal = dmem_addr[0];
    end else if (dmem_size == MEM_TYPE_WIDTH'(2)) begin
      misal = (dmem_addr[1:0] != 2'b00);
    end
  end

  assign tmo_fire = TMO_EN && (state == S_BUS) && !hready && (tmo_cnt == TMO_LAST);
  assign advance  = (state != S_BUS) || hready || tmo_fire;
  assign accept   = (htrans == HTRANS_NONSEQ) && hready;

  // Address phase and data-phase outputs; no new transfer is issued while an
  // error response or a forced timeout completion is in progress, or in reset.
  always_comb begin
    haddr         = dmem_addr;
    hwrite        = dmem_wen;
    hsize         = {1'b0, dmem_size[1:0]};
    htrans        = HTRANS_IDLE;
    if (reset && dmem_en && !misal && !((state == S_BUS) && hresp) && !tmo_fire) begin
      htrans = HTRANS_NONSEQ;
    end
    dmem_wait     = (state == S_BUS) && !hready && !tmo_fire;
    dmem_badmem_e = (state == S_MISAL) || ((state == S_BUS) && hready && hresp) || tmo_fire;
    dmem_rdata    = (state == S_BUS) ? hrdata : '0;
    hwdata        = ((state == S_BUS) && wr_q) ? dmem_wdata_delayed : '0;
  end

  // Next data phase: bus transfer if accepted, local fault if misaligned.
  always_comb begin
    state_next = state;
    if (advance) begin
      if (accept) begin
        state_next = S_BUS;
      end else if (dmem_en && misal) begin
        state_next = S_MISAL;
      end else begin
        state_next = S_IDLE;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Wait-state counter for the current bus data phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (advance) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  // Remember whether the accepted transfer is a write so hwdata is driven
  // only during write data phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= 1'b0;
    end else if (advance) begin
      wr_q <= accept && hwrite;
    end
  end

  // Sticky record that a hung slave was abandoned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_flag <= 1'b0;
    end else if (tmo_fire) begin
      timeout_flag <= 1'b1;
    end
  end

  assign state_dbg = state;

endmodule
